// File: rtl/bcd_sseg_scan.sv
// Time-multiplexed 7-segment scanner for a packed BCD word.
// The BCD word and decimal points are captured once per scan frame so a frame never mixes
// two input values. Digits are scanned one at a time, each held for 2**REFRESH_BITS clocks.
// an_o and sseg_o are active-low.
// Optional feature: define BCD_SSEG_LZ_BLANK_EN to blank leading zeros, working from the MSD
// down; digit 0 is never blanked.
module bcd_sseg_scan #(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned REFRESH_BITS = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [7:0]              sseg_o,
  output logic                    frame_tick_o
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_bcd_q, snap_bcd_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              sseg_q, sseg_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    wrap;
  logic                    frame_end;
  logic [3:0]              digit_sel;
  logic                    dp_sel;
  logic                    blank_sel;
  logic [NUM_DIGITS-1:0]   blank;

  // Active-low segment pattern g..a; non-BCD codes show a dash.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

`ifdef BCD_SSEG_LZ_BLANK_EN
  logic lead_zero;

  // Leading-zero mask: a digit is blanked only while every digit above it is also zero.
  always_comb begin
    blank     = '0;
    lead_zero = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
      lead_zero = lead_zero && (snap_bcd_q[4*k +: 4] == 4'd0);
      blank[k]  = lead_zero;
    end
  end
`else
  // Every digit is always shown.
  always_comb begin
    blank = '0;
  end
`endif

  // Refresh counter, digit index and frame-boundary snapshot next state.
  always_comb begin
    wrap         = &refresh_q;
    frame_end    = wrap && (idx_q == LastIdx);
    refresh_d    = refresh_q + 1'b1;
    idx_d        = idx_q;
    snap_bcd_d   = snap_bcd_q;
    snap_dp_d    = snap_dp_q;
    frame_tick_d = frame_end;
    if (wrap) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
    if (frame_end) begin
      snap_bcd_d = bcd_i;
      snap_dp_d  = dp_i;
    end
  end

  // Select the current digit of the snapshot and build the registered outputs.
  always_comb begin
    digit_sel = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IdxW'(k)) begin
        digit_sel = snap_bcd_q[4*k +: 4];
        dp_sel    = snap_dp_q[k];
        blank_sel = blank[k];
      end
    end
    if (blank_sel) begin
      an_d   = '1;
      sseg_d = 8'hFF;
    end else begin
      an_d   = ~(NUM_DIGITS'(1) << idx_q);
      sseg_d = {~dp_sel, seg7(digit_sel)};
    end
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      refresh_q    <= '0;
      idx_q        <= '0;
      snap_bcd_q   <= '0;
      snap_dp_q    <= '0;
      an_q         <= '1;
      sseg_q       <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      refresh_q    <= refresh_d;
      idx_q        <= idx_d;
      snap_bcd_q   <= snap_bcd_d;
      snap_dp_q    <= snap_dp_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an_o         = an_q;
  assign sseg_o       = sseg_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_bcd_sseg_scan.sv
// Scoreboard bench for bcd_sseg_scan with REFRESH_BITS=2, NUM_DIGITS=2 (8-cycle frames).
// Honours BCD_SSEG_LZ_BLANK_EN in its expectations when the macro is defined.
module tb_bcd_sseg_scan;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] bcd_i;
  logic [1:0] dp_i;
  logic [1:0] an_o;
  logic [7:0] sseg_o;
  logic       frame_tick_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] cnt;

  typedef struct packed {
    logic [1:0] an;
    logic [7:0] sseg;
  } exp_t;

  exp_t exp_q[$];

  bcd_sseg_scan #(
    .NUM_DIGITS  (2),
    .REFRESH_BITS(2)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bcd_i       (bcd_i),
    .dp_i        (dp_i),
    .an_o        (an_o),
    .sseg_o      (sseg_o),
    .frame_tick_o(frame_tick_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Expected slot contents for a frame showing snapshot b/dp: digit 0 slot, then digit 1 slot.
  task automatic push_frame(input logic [7:0] b, input logic [1:0] dp);
    exp_t e;
    logic blank1;
`ifdef BCD_SSEG_LZ_BLANK_EN
    blank1 = (b[7:4] == 4'd0);
`else
    blank1 = 1'b0;
`endif
    e.an   = 2'b10;
    e.sseg = {~dp[0], seg7(b[3:0])};
    exp_q.push_back(e);
    if (blank1) begin
      e.an   = 2'b11;
      e.sseg = 8'hFF;
    end else begin
      e.an   = 2'b01;
      e.sseg = {~dp[1], seg7(b[7:4])};
    end
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb_avail"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_an"}, 32'(an_o), 32'(e.an));
      check({tag, "_sseg"}, 32'(sseg_o), 32'(e.sseg));
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One 8-cycle frame. Table mode: next value applied mid-frame (c=3), junk right after the
  // capture edge (c=8). Live mode: bcd_i follows a BCD counter that advances every cycle.
  task automatic run_frame(input logic [7:0] nb, input logic [1:0] ndp, input bit live,
                           input bit first);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (live) begin
        bcd_i = cnt;
        cnt   = bcd_inc(cnt);
      end
      check("frame_tick", 32'(frame_tick_o), 32'(c == 8));
      if (first && c == 1) begin
        check("first_an", 32'(an_o), 32'h2);
        check("first_sseg", 32'(sseg_o), 32'hC0);
      end
      if (c == 2) pop_check("dig0");
      if (c == 6) pop_check("dig1");
      if (!live && c == 3) begin
        bcd_i = nb;
        dp_i  = ndp;
      end
      if (c == 7) push_frame(bcd_i, dp_i);
      if (!live && c == 8) begin
        bcd_i = ~nb;
        dp_i  = ~ndp;
      end
    end
  endtask

  initial begin
    exp_t e;
    bcd_i = 8'h99;
    dp_i  = 2'b11;
    cnt   = 8'h90;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_an", 32'(an_o), 32'h3);
    check("rst_sseg", 32'(sseg_o), 32'hFF);
    check("rst_tick", 32'(frame_tick_o), 32'h0);

    @(negedge clk_i);
    rst_ni = 1'b1;
    push_frame(8'h00, 2'b00);
    run_frame(8'h37, 2'b01, 1'b0, 1'b1);

    // Decode sweep on digit 0; tens digit 1 keeps digit 1 visible.
    for (int k = 0; k < 16; k++) begin
      run_frame({4'h1, 4'(k)}, 2'b10, 1'b0, 1'b0);
    end

    run_frame(8'h05, 2'b00, 1'b0, 1'b0);
    run_frame(8'h00, 2'b00, 1'b0, 1'b0);
    run_frame(8'h00, 2'b00, 1'b0, 1'b0);

    dp_i = 2'b00;
    for (int f = 0; f < 30; f++) begin
      run_frame(8'h00, 2'b00, 1'b1, 1'b0);
    end

    // Async reset in the middle of the digit-1 slot.
    repeat (5) step();
    check("pre_rst_sb", 32'(exp_q.size()), 32'd2);
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      e = exp_q[0];
      check("pre_rst_an", 32'(an_o), 32'(e.an));
    end
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_an", 32'(an_o), 32'h3);
    check("async_rst_sseg", 32'(sseg_o), 32'hFF);
    check("async_rst_tick", 32'(frame_tick_o), 32'h0);
    exp_q.delete();
    bcd_i = 8'h42;
    dp_i  = 2'b11;
    @(negedge clk_i);
    rst_ni = 1'b1;
    push_frame(8'h00, 2'b00);
    run_frame(8'h12, 2'b00, 1'b0, 1'b1);
    run_frame(8'h64, 2'b11, 1'b0, 1'b0);
    run_frame(8'h08, 2'b00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
